instr_fetch_spi: RTL and testbench
==================================

INSTR_FETCH_SPI -- requirements
Module: instr_fetch_spi

Interface
REQ-001 Parameter: ADDR_BITS, 24, number of PCF bits sent as the SPI flash address (other values out of scope).
REQ-002 Parameter: READ_CMD, 8'h03, SPI read command byte.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 PCF  input  32  current PC value from the PC register.
REQ-006 req  input  1  fetch request; sampled only in IDLE.
REQ-007 flush  input  1  abort the in-flight fetch (taken branch/jump).
REQ-008 InstrF  output  32  last completed instruction word; registered.
REQ-009 valid  output  1  one-cycle pulse when InstrF holds a new word.
REQ-010 busy  output  1  high while a transaction is shifting; drives PC EN as ~busy.
REQ-011 spi_cs_n  output  1  flash chip select, active-low; registered.
REQ-012 spi_sck  output  1  SPI clock, mode 0; registered.
REQ-013 spi_mosi  output  1  serial data to flash; registered.
REQ-014 spi_miso  input  1  serial data from flash.

Function
REQ-015 States SHALL be IDLE, SHIFT, DONE; busy = (state == SHIFT); valid = (state == DONE).
REQ-016 In IDLE with req=1 and flush=0, edge E0 SHALL latch frame = {READ_CMD, PCF[23:0], 32'h0}, clear the 7-bit bit counter, enter SHIFT with cs_n=0, sck=0, mosi=frame[63].
REQ-017 PCF changes after E0 SHALL be ignored until the next accept; PCF[31:24] SHALL be ignored.
REQ-018 Each bit SHALL take 2 CLK cycles: low phase (sck=0), then an edge sets sck=1, then an edge sets sck=0.
REQ-019 The edge that sets sck 1->0 SHALL sample spi_miso, shift the frame left by one, update mosi to the next frame bit, and increment the counter.
REQ-020 Bits are sent MSB first; mosi SHALL be 0 during the 32 data bits.
REQ-021 Data bits SHALL be assembled byte-little-endian: first received byte -> InstrF[7:0], second -> [15:8], third -> [23:16], fourth -> [31:24]; MSB first within each byte.
REQ-022 At the sampling edge for bit 63 (edge E0+128), the block SHALL load InstrF, set cs_n=1, sck=0, mosi=0, and enter DONE.
REQ-023 DONE SHALL last exactly one cycle and then enter IDLE; req is not accepted in DONE, giving at least 2 cycles of cs_n high between transactions.
REQ-024 flush=1 in SHIFT SHALL, at the next edge, set cs_n=1, sck=0, mosi=0 and enter IDLE; valid stays 0 and InstrF is unchanged.
REQ-025 flush=1 in IDLE SHALL block acceptance of a simultaneous req; flush in DONE SHALL be ignored.
REQ-026 InstrF SHALL hold its value between completions.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, InstrF=0, valid=0, busy=0, cs_n=1, sck=0, mosi=0, counter=0, frame=0, regardless of CLK.
REQ-028 Reset asserted mid-transaction SHALL discard the transaction; the first req after deassertion starts a fresh command.

Verification
REQ-029 Reset: assert reset between edges -> outputs take REQ-027 values without a clock edge.
REQ-030 Fetch: PCF=32'h00000104, req pulse; flash model returns 13 05 00 00 -> MOSI carries 0x03 then 0x000104, 64 sck rising edges, InstrF=32'h00000513, valid high only in the cycle after edge E0+128.
REQ-031 Address truncation: PCF=32'hFF000010 -> address bytes sent are 00 00 10.
REQ-032 Flush: flush=1 during bit 40 -> cs_n=1 after the next edge, no valid pulse, InstrF unchanged; the next req sends a full new 0x03 command.
REQ-033 Async reset during the data phase -> cs_n=1 immediately, valid never pulses, InstrF=0.
REQ-034 Back-to-back: req held high -> second accept at edge E0+130, cs_n high for exactly 2 cycles between frames, both words correct.

Source files
------------

// File: rtl/instr_fetch_spi.sv
// SPI flash instruction fetcher: issues READ_CMD + 24-bit address, clocks in one
// 32-bit word (byte-little-endian) and presents it on InstrF with a valid pulse.
module instr_fetch_spi #(
    parameter int          ADDR_BITS = 24,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        req,
    input  logic        flush,
    output logic [31:0] InstrF,
    output logic        valid,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state, w_state;
    logic [63:0] r_frame, w_frame;
    logic [6:0]  r_cnt,   w_cnt;
    logic [31:0] r_rx,    w_rx;
    logic [31:0] r_instr, w_instr;
    logic        r_cs_n,  w_cs_n;
    logic        r_sck,   w_sck;
    logic        r_mosi,  w_mosi;
    logic [31:0] w_word;
    logic        w_unused;

    // Upper PC bits never reach the flash; the window is ADDR_BITS wide.
    assign w_unused = ^PCF[31:ADDR_BITS];

    // Word as it stands after the current sampling edge.
    assign w_word = {r_rx[30:0], spi_miso};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_instr <= '0;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_frame <= w_frame;
            r_cnt   <= w_cnt;
            r_rx    <= w_rx;
            r_instr <= w_instr;
            r_cs_n  <= w_cs_n;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
        end
    end

    always_comb begin
        w_state = r_state;
        w_frame = r_frame;
        w_cnt   = r_cnt;
        w_rx    = r_rx;
        w_instr = r_instr;
        w_cs_n  = r_cs_n;
        w_sck   = r_sck;
        w_mosi  = r_mosi;
        case (r_state)
            IDLE: begin
                if (req && !flush) begin
                    w_frame = {READ_CMD, PCF[ADDR_BITS-1:0], 32'h0};
                    w_cnt   = '0;
                    w_state = SHIFT;
                    w_cs_n  = 1'b0;
                    w_sck   = 1'b0;
                    w_mosi  = READ_CMD[7];
                end
            end
            SHIFT: begin
                if (flush) begin
                    w_state = IDLE;
                    w_cs_n  = 1'b1;
                    w_sck   = 1'b0;
                    w_mosi  = 1'b0;
                end else if (!r_sck) begin
                    w_sck = 1'b1;
                end else begin
                    // Falling sck edge: sample, advance the frame, count the bit.
                    w_sck   = 1'b0;
                    w_rx    = w_word;
                    w_frame = {r_frame[62:0], 1'b0};
                    w_mosi  = r_frame[62];
                    w_cnt   = r_cnt + 7'd1;
                    if (r_cnt == 7'd63) begin
                        // First received byte lands in the low byte of the word.
                        w_instr = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
                        w_state = DONE;
                        w_cs_n  = 1'b1;
                        w_mosi  = 1'b0;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
                w_cs_n  = 1'b1;
                w_sck   = 1'b0;
                w_mosi  = 1'b0;
            end
        endcase
    end

    assign InstrF   = r_instr;
    assign valid    = (r_state == DONE);
    assign busy     = (r_state == SHIFT);
    assign spi_cs_n = r_cs_n;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_instr_fetch_spi.sv
// Directed bench for instr_fetch_spi with a behavioural SPI flash model.
module tb_instr_fetch_spi;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = '0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] InstrF;
    logic        valid, busy, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;

    int total = 0;
    int bad = 0;

    instr_fetch_spi dut (
        .CLK(CLK), .reset(reset), .PCF(PCF), .req(req), .flush(flush),
        .InstrF(InstrF), .valid(valid), .busy(busy), .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 CLK = ~CLK;

    // Flash model: stream holds the four data bytes in send order (first byte in [31:24]).
    logic [31:0] stream = '0;
    logic [63:0] mosi_cap = '0;
    int          rises = 0;

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (spi_sck) begin
            mosi_cap = {mosi_cap[62:0], spi_mosi};
            rises    = rises + 1;
            spi_miso = (rises > 32) ? stream[64 - rises] : rises[0];
        end else begin
            mosi_cap = '0;
            rises    = 0;
            spi_miso = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Waits (bounded) from the negedge after E0 until valid; returns edges elapsed.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 300) begin
            @(negedge CLK);
            n++;
        end
    endtask

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] stream;
        logic [31:0] exp_instr;
        logic [31:0] exp_cmd;
    } vec_t;

    vec_t vecs[5];

    task automatic run_fetch(input vec_t v, input string nm);
        int n;
        @(negedge CLK);
        PCF = v.pcf;
        stream = v.stream;
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        PCF = $urandom;
        chk({nm, " busy"}, 64'(busy), 64'd1);
        wait_valid(n);
        chk({nm, " latency"}, 64'(n), 64'd128);
        chk({nm, " instr"}, 64'(InstrF), 64'(v.exp_instr));
        chk({nm, " cmd"}, 64'(mosi_cap[63:32]), 64'(v.exp_cmd));
        chk({nm, " mosi_data"}, 64'(mosi_cap[31:0]), 64'd0);
        chk({nm, " sck_rises"}, 64'(rises), 64'd64);
        @(negedge CLK);
        chk({nm, " valid_width"}, 64'(valid), 64'd0);
        chk({nm, " instr_hold"}, 64'(InstrF), 64'(v.exp_instr));
    endtask

    initial begin
        int n;
        int pulses;
        vecs[0] = '{32'h00000104, 32'h13050000, 32'h00000513, 32'h03000104};
        vecs[1] = '{32'hFF000010, 32'hAABBCCDD, 32'hDDCCBBAA, 32'h03000010};
        vecs[2] = '{32'h12345678, 32'h01234567, 32'h67452301, 32'h03345678};
        vecs[3] = '{32'h00FFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h03FFFFFC};
        vecs[4] = '{32'h80000000, 32'h80000001, 32'h01000080, 32'h03000000};

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst instr", 64'(InstrF), 64'd0);
        chk("rst ctl", 64'({valid, busy, spi_cs_n, spi_sck, spi_mosi}), 64'b00100);
        @(negedge CLK);
        reset = 1'b0;

        foreach (vecs[i]) run_fetch(vecs[i], $sformatf("vec%0d", i));

        // flush alongside req in IDLE blocks the accept
        @(negedge CLK);
        req = 1'b1;
        flush = 1'b1;
        @(negedge CLK);
        chk("idle_flush busy", 64'(busy), 64'd0);
        chk("idle_flush cs_n", 64'(spi_cs_n), 64'd1);
        req = 1'b0;
        flush = 1'b0;

        // Flush during bit 40
        stream = 32'h11223344;
        PCF = 32'h00000200;
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (80) @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        chk("flush ctl", 64'({busy, spi_cs_n, spi_sck, spi_mosi}), 64'b0100);
        @(negedge CLK);
        flush = 1'b0;
        pulses = 0;
        repeat (140) begin
            @(negedge CLK);
            if (valid) pulses++;
        end
        chk("flush no_valid", 64'(pulses), 64'd0);
        chk("flush instr", 64'(InstrF), 64'h01000080);
        run_fetch(vecs[0], "post_flush");

        // Async reset during the data phase
        @(negedge CLK);
        PCF = 32'h00000300;
        stream = 32'hDEADBEEF;
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (90) @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        chk("arst ctl", 64'({valid, busy, spi_cs_n, spi_sck, spi_mosi}), 64'b00100);
        chk("arst instr", 64'(InstrF), 64'd0);
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        pulses = 0;
        repeat (140) begin
            @(negedge CLK);
            if (valid) pulses++;
        end
        chk("arst no_valid", 64'(pulses), 64'd0);
        chk("arst instr_hold", 64'(InstrF), 64'd0);
        run_fetch(vecs[2], "post_rst");

        // Back-to-back with req held high
        @(negedge CLK);
        PCF = 32'h00000104;
        stream = 32'h13050000;
        req = 1'b1;
        @(negedge CLK);
        wait_valid(n);
        chk("b2b lat1", 64'(n), 64'd128);
        chk("b2b instr1", 64'(InstrF), 64'h00000513);
        chk("b2b cmd1", 64'(mosi_cap[63:32]), 64'h03000104);
        chk("b2b gap1", 64'({spi_cs_n, busy}), 64'b10);
        PCF = 32'h00000108;
        stream = 32'h93001000;
        @(negedge CLK);
        chk("b2b gap2", 64'({spi_cs_n, busy, valid}), 64'b100);
        @(negedge CLK);
        chk("b2b accept2", 64'({spi_cs_n, busy}), 64'b01);
        req = 1'b0;
        wait_valid(n);
        chk("b2b lat2", 64'(n), 64'd128);
        chk("b2b instr2", 64'(InstrF), 64'h00100093);
        chk("b2b cmd2", 64'(mosi_cap[63:32]), 64'h03000108);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
